// File: rtl/w_schedule_gen_if.sv
// Block-in / round-out bus between the padding unit, the schedule generator
// and the round processor.
interface w_schedule_gen_if #(
  parameter int unsigned CNT_W = 7
);
  logic [511:0]     i_block;
  logic             i_block_valid;
  logic             o_block_ready;
  logic             i_stall;
  logic [31:0]      o_w;
  logic [31:0]      o_k;
  logic [CNT_W-1:0] o_count;
  logic             o_round_valid;
  logic             o_done;

  // master: block source and round consumer
  modport master (
    output i_block, i_block_valid, i_stall,
    input  o_block_ready, o_w, o_k, o_count, o_round_valid, o_done
  );

  // slave: the schedule generator
  modport slave (
    input  i_block, i_block_valid, i_stall,
    output o_block_ready, o_w, o_k, o_count, o_round_valid, o_done
  );
endinterface

// File: rtl/w_schedule_gen.sv
// SHA-256 message schedule and round-constant source: expands one 512-bit block
// into W0..W63 and streams (W_t, K_t, t) one per cycle, then emits count 64/65.
module w_schedule_gen #(
  parameter int unsigned ROUNDS = 64,
  parameter int unsigned CNT_W  = 7
) (
  input logic              i_clk,
  input logic              i_rst,
  w_schedule_gen_if.slave  bus
);
  localparam int unsigned WORD_W = 32;
  localparam int unsigned BUF_N  = 16;
  localparam int unsigned T_W    = 6;

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [WORD_W-1:0]  wbuf [BUF_N];
  logic [WORD_W-1:0]  w_q, w_nxt, k_q, k_nxt;
  logic [CNT_W-1:0]   count_q, count_nxt;
  logic               rv_q, rv_nxt, done_q, done_nxt;
  logic               buf_load, buf_we, last;
  logic [T_W-1:0]     t_nxt;
  logic [3:0]         slot;
  logic [WORD_W-1:0]  sched_w;

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  assign last  = (count_q == CNT_W'(ROUNDS - 1));
  assign t_nxt = T_W'(count_q) + T_W'(1);
  assign slot  = t_nxt[3:0];

  // Slot t mod 16 still holds W[t-16]; the other taps sit at fixed offsets around it.
  assign sched_w = ssig1(wbuf[slot + 4'd14]) + wbuf[slot + 4'd9]
                 + ssig0(wbuf[slot + 4'd1]) + wbuf[slot];

  always_ff @(posedge i_clk) begin
    if (!i_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.i_block_valid) state_nxt = RUN;
      RUN:     if (!bus.i_stall && last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered round outputs and buffer write controls.
  always_comb begin
    w_nxt     = w_q;
    k_nxt     = k_q;
    count_nxt = count_q;
    rv_nxt    = rv_q;
    done_nxt  = 1'b0;
    buf_load  = 1'b0;
    buf_we    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.i_block_valid) begin
          buf_load  = 1'b1;
          count_nxt = '0;
          w_nxt     = bus.i_block[511 -: WORD_W];
          k_nxt     = K_ROM[0];
          rv_nxt    = 1'b1;
        end
      end
      RUN: begin
        if (!bus.i_stall) begin
          if (last) begin
            count_nxt = CNT_W'(ROUNDS);
            rv_nxt    = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            count_nxt = CNT_W'(t_nxt);
            k_nxt     = K_ROM[t_nxt];
            if (t_nxt < T_W'(BUF_N)) begin
              w_nxt = wbuf[slot];
            end else begin
              w_nxt  = sched_w;
              buf_we = 1'b1;
            end
          end
        end
      end
      DONE:    count_nxt = CNT_W'(ROUNDS + 1);
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      w_q     <= '0;
      k_q     <= '0;
      count_q <= '0;
      rv_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      w_q     <= w_nxt;
      k_q     <= k_nxt;
      count_q <= count_nxt;
      rv_q    <= rv_nxt;
      done_q  <= done_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int i = 0; i < BUF_N; i++) wbuf[i] <= '0;
    end else if (buf_load) begin
      for (int i = 0; i < BUF_N; i++) wbuf[i] <= bus.i_block[WORD_W*(BUF_N-i)-1 -: WORD_W];
    end else if (buf_we) begin
      wbuf[slot] <= sched_w;
    end
  end

  assign bus.o_block_ready = (state == IDLE);
  assign bus.o_w           = w_q;
  assign bus.o_k           = k_q;
  assign bus.o_count       = count_q;
  assign bus.o_round_valid = rv_q;
  assign bus.o_done        = done_q;
endmodule

// File: tb/tb_w_schedule_gen.sv
// Directed bench for w_schedule_gen with a reference schedule model and a
// scoreboard of expected (W_t, K_t, t) tuples.
module tb_w_schedule_gen;
  typedef struct packed {
    logic [31:0] w;
    logic [31:0] k;
    logic [6:0]  t;
  } tuple_t;

  localparam logic [31:0] K_REF [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic i_clk = 1'b0;
  logic i_rst;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  tuple_t sb[$];

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  w_schedule_gen_if #(.CNT_W(7)) bus ();
  w_schedule_gen #(.ROUNDS(64), .CNT_W(7)) dut (.i_clk(i_clk), .i_rst(i_rst), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference SHA-256 schedule: fill all 64 words, then queue the tuples.
  function automatic void push_block(input logic [511:0] blk);
    logic [31:0] wm [64];
    logic [31:0] a, b;
    for (int i = 0; i < 16; i++) wm[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      a = rotr(wm[i-15], 7) ^ rotr(wm[i-15], 18) ^ (wm[i-15] >> 3);
      b = rotr(wm[i-2], 17) ^ rotr(wm[i-2], 19) ^ (wm[i-2] >> 10);
      wm[i] = b + wm[i-7] + a + wm[i-16];
    end
    for (int i = 0; i < 64; i++) sb.push_back('{w: wm[i], k: K_REF[i], t: 7'(i)});
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Called #1 after an edge while in IDLE; returns #1 after the handshake edge.
  task automatic send(input logic [511:0] blk);
    chk("ready_before_send", 32'(bus.o_block_ready), 32'd1);
    bus.i_block       = blk;
    bus.i_block_valid = 1'b1;
    push_block(blk);
    @(posedge i_clk); #1;
    bus.i_block_valid = 1'b0;
  endtask

  task automatic stream(input bit abc, input int stall_at, input int stall_n,
                        input int inject_at, input int abort_at, output int t0);
    tuple_t cur;
    int     left = stall_n;
    int     frozen = 0;
    int     rounds = 0;
    bit     stalled;
    bit     fin = 1'b0;
    t0 = cyc;
    cur = sb.pop_front();
    for (int g = 0; g < 120; g++) begin
      chk("round_valid", 32'(bus.o_round_valid), 32'd1);
      chk("ready_in_run", 32'(bus.o_block_ready), 32'd0);
      chk("done_in_run", 32'(bus.o_done), 32'd0);
      chk($sformatf("w_t%0d", cur.t), bus.o_w, cur.w);
      chk($sformatf("k_t%0d", cur.t), bus.o_k, cur.k);
      chk("count", 32'(bus.o_count), 32'(cur.t));
      if (abc && cur.t == 7'd0)  begin chk("abc_w0", bus.o_w, 32'h61626380); chk("abc_k0", bus.o_k, 32'h428a2f98); end
      if (abc && cur.t == 7'd16) chk("abc_w16", bus.o_w, 32'h61626380);
      if (abc && cur.t == 7'd17) chk("abc_w17", bus.o_w, 32'h000f0000);
      if (abc && cur.t == 7'd63) chk("abc_k63", bus.o_k, 32'hc67178f2);
      if (int'(cur.t) == stall_at) frozen++;
      if (int'(cur.t) == abort_at) begin
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        chk("abort_count", 32'(bus.o_count), 32'd0);
        chk("abort_rv", 32'(bus.o_round_valid), 32'd0);
        chk("abort_ready", 32'(bus.o_block_ready), 32'd1);
        chk("abort_done", 32'(bus.o_done), 32'd0);
        chk("abort_w", bus.o_w, 32'd0);
        chk("abort_k", bus.o_k, 32'd0);
        sb.delete();
        return;
      end
      stalled = (int'(cur.t) == stall_at) && (left > 0);
      if (stalled) left--;
      bus.i_stall       = stalled;
      bus.i_block_valid = (int'(cur.t) == inject_at);
      if (int'(cur.t) == inject_at) bus.i_block = rand_block();
      @(posedge i_clk); #1;
      bus.i_stall       = 1'b0;
      bus.i_block_valid = 1'b0;
      if (!stalled) begin
        rounds++;
        if (cur.t == 7'd63) begin fin = 1'b1; break; end
        if (sb.size() == 0) break;
        cur = sb.pop_front();
      end
    end
    chk("stream_completed", 32'(fin), 32'd1);
    chk("rounds_presented", 32'(rounds), 32'd64);
    if (stall_n > 0) chk("frozen_observations", 32'(frozen), 32'(stall_n + 1));
    // DONE cycle: stall is asserted here and must be ignored.
    bus.i_stall = 1'b1;
    chk("done_count", 32'(bus.o_count), 32'd64);
    chk("done_pulse", 32'(bus.o_done), 32'd1);
    chk("done_rv", 32'(bus.o_round_valid), 32'd0);
    chk("done_ready", 32'(bus.o_block_ready), 32'd0);
    chk("done_w_hold", bus.o_w, cur.w);
    chk("done_k_hold", bus.o_k, cur.k);
    @(posedge i_clk); #1;
    bus.i_stall = 1'b0;
    chk("idle_count", 32'(bus.o_count), 32'd65);
    chk("idle_done", 32'(bus.o_done), 32'd0);
    chk("idle_ready", 32'(bus.o_block_ready), 32'd1);
    chk("idle_rv", 32'(bus.o_round_valid), 32'd0);
  endtask

  initial begin
    logic [511:0] abc_blk;
    int t0a, t0b, dummy;
    abc_blk = {32'h61626380, 448'd0, 32'h00000018};
    i_rst = 1'b0;
    bus.i_block = '0;
    bus.i_block_valid = 1'b0;
    bus.i_stall = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_count", 32'(bus.o_count), 32'd0);
    chk("rst_rv", 32'(bus.o_round_valid), 32'd0);
    chk("rst_done", 32'(bus.o_done), 32'd0);
    chk("rst_w", bus.o_w, 32'd0);
    chk("rst_k", bus.o_k, 32'd0);
    chk("rst_ready", 32'(bus.o_block_ready), 32'd1);
    i_rst = 1'b1;
    // stall in IDLE without a block: nothing moves
    bus.i_stall = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    bus.i_stall = 1'b0;
    chk("idle_hold_count", 32'(bus.o_count), 32'd0);
    chk("idle_hold_rv", 32'(bus.o_round_valid), 32'd0);

    send(abc_blk);
    stream(1'b1, -1, 0, -1, -1, dummy);

    repeat (3) @(posedge i_clk);
    #1;
    chk("count_65_held", 32'(bus.o_count), 32'd65);
    send(abc_blk);
    stream(1'b1, 20, 3, -1, -1, dummy);

    send(abc_blk);
    stream(1'b1, -1, 0, 5, -1, dummy);

    send(abc_blk);
    stream(1'b1, -1, 0, -1, 30, dummy);
    bus.i_stall = 1'b1;
    send(abc_blk);
    stream(1'b1, -1, 0, -1, -1, dummy);

    send(rand_block());
    stream(1'b0, -1, 0, -1, -1, t0a);
    send(rand_block());
    stream(1'b0, 40, 1, -1, -1, t0b);
    chk("back_to_back_gap", 32'(t0b - t0a), 32'd66);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
